// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Drains words from a synchronous FIFO read port and serialises each word as an
// asynchronous UART frame. Each frame is a start bit (0), data_width data bits
// sent LSB first, an optional even-parity bit, and a stop bit (1). Every bit is
// held for clks_per_bit clock cycles. Exactly one word is popped per frame, and
// the FIFO is only popped from IDLE after fifo_empty has been seen low.
//
// Build option:
//   FIFO_UART_TX_PARITY_EN  when defined, a PARITY state sits between DATA and
//                           STOP and drives the XOR of the data bits (even
//                           parity). When undefined, DATA goes straight to STOP
//                           and no parity logic exists.
//
// Parameters:
//   data_width    width of each FIFO word and data bits per frame (>= 1)
//   clks_per_bit  clk cycles per serial bit, i.e. baud divisor    (>= 2)
//
// Ports:
//   clk         in   system clock, all state changes on the rising edge
//   clr         in   synchronous active-high reset, overrides everything
//   fifo_empty  in   FIFO empty flag, looked at only in IDLE
//   fifo_data   in   FIFO registered read data, valid the cycle after a read
//   fifo_rd_en  out  one-cycle read strobe, high only in FETCH
//   tx          out  registered serial line, idles high
//   busy        out  high whenever the FSM is not in IDLE
//   frame_done  out  one-cycle pulse in the IDLE cycle that follows a stop bit
//
// Handshake: the FIFO side is a plain read-strobe interface. A word is
// requested by a single fifo_rd_en cycle (FETCH); the FIFO presents it on
// fifo_data during the following cycle (LOAD), where it is captured. There is
// no back-pressure from the serial side; the next word is only requested once
// the current frame, including its stop bit, has been fully sent.
//
// The FSM state is held in the internal signal 'state' (enum type tx_state_t)
// so checkers can bind to it directly.
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int data_width   = 8,
    parameter int clks_per_bit = 16
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  fifo_empty,
    input  logic [data_width-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    // Baud counter runs 0..clks_per_bit-1 inside every serial bit.
    localparam int BAUD_W = $clog2(clks_per_bit);
    // Bit counter has one spare bit so that reaching data_width never wraps.
    localparam int BIT_W  = $clog2(data_width) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(clks_per_bit - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(data_width - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY = 3'd6,
`endif
        STOP   = 3'd5
    } tx_state_t;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    tx_state_t              state;
    logic [data_width-1:0]  shreg;
    logic [BAUD_W-1:0]      baud_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic                   tx_q;
    logic                   frame_done_q;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                   parity_q;
`endif

    // Next-state values
    tx_state_t              state_n;
    logic [data_width-1:0]  shreg_n;
    logic [BAUD_W-1:0]      baud_n;
    logic [BIT_W-1:0]       bit_n;
    logic                   tx_n;
    logic                   done_n;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                   parity_n;
`endif

    // Last cycle of the serial bit currently on the line.
    logic                   baud_last;

    assign baud_last = (baud_cnt == BAUD_LAST);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            state        <= IDLE;
            shreg        <= '0;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            tx_q         <= 1'b1;
            frame_done_q <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            shreg        <= shreg_n;
            baud_cnt     <= baud_n;
            bit_cnt      <= bit_n;
            tx_q         <= tx_n;
            frame_done_q <= done_n;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q     <= parity_n;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        baud_n   = baud_cnt;
        bit_n    = bit_cnt;
        done_n   = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_n = parity_q;
`endif

        case (state)
            IDLE: begin
                // The only place fifo_empty is consulted, so a word that
                // arrives mid-frame is picked up here after the stop bit.
                if (!fifo_empty) begin
                    state_n = FETCH;
                end
            end

            FETCH: begin
                state_n = LOAD;
            end

            LOAD: begin
                // Registered FIFO data is valid now, one cycle after the strobe.
                shreg_n  = fifo_data;
                baud_n   = '0;
                bit_n    = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_n = ^fifo_data;
`endif
                state_n  = START;
            end

            START: begin
                if (baud_last) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end else begin
                    baud_n  = baud_cnt + 1'b1;
                end
            end

            DATA: begin
                if (baud_last) begin
                    baud_n  = '0;
                    shreg_n = shreg >> 1;
                    bit_n   = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end else begin
                    baud_n  = baud_cnt + 1'b1;
                end
            end

`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last) begin
                    baud_n  = '0;
                    state_n = STOP;
                end else begin
                    baud_n  = baud_cnt + 1'b1;
                end
            end
`endif

            STOP: begin
                if (baud_last) begin
                    baud_n  = '0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    baud_n  = baud_cnt + 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Line level for the coming cycle. Deriving it from the next state keeps tx
    // a flop output that always matches the current state without a cycle of
    // lag, and the line never sees decode glitches.
    // -------------------------------------------------------------------------
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY:  tx_n = parity_n;
`endif
            default: tx_n = 1'b1;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign fifo_rd_en = (state == FETCH);
    assign busy       = (state != IDLE);
    assign tx         = tx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FB = DW + 3;
`else
  localparam int FB = DW + 2;
`endif
  localparam int FRAME   = FB * CPB;
  localparam int SPACING = FRAME + 3;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd_en;
  logic          tx;
  logic          busy;
  logic          frame_done;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .data_width   (DW),
    .clks_per_bit (CPB)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // ---------------------------------------------------------------------------
  // Bench state
  // ---------------------------------------------------------------------------
  int            tests_run    = 0;
  int            tests_failed = 0;
  int            cyc          = 0;
  int            rd_cnt       = 0;
  int            done_cnt     = 0;
  int            mon_frames   = 0;
  int            last_rd_cyc  = -1;
  int            last_done_cyc = -1;
  logic          last_done_busy = 1'b1;
  logic          wr_en   = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  int            start_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural synchronous FIFO: registered read data, empty flag updated on
  // the clock edge, cleared by the shared clr.
  always @(posedge clk) begin
    if (clr) begin
      fq.delete();
      fifo_empty <= 1'b1;
      fifo_data  <= '0;
    end else begin
      if (fifo_rd_en === 1'b1) begin
        tests_run++;
        if (fq.size() == 0) begin
          tests_failed++;
          $display("FAIL rd_while_empty: fifo_rd_en=1 with FIFO empty at cycle %0d (required no read)", cyc);
        end else begin
          fifo_data <= fq.pop_front();
        end
      end
      if (wr_en) fq.push_back(wr_data);
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Strobe / pulse bookkeeping.
  always @(negedge clk) begin
    if (fifo_rd_en === 1'b1) begin
      rd_cnt++;
      last_rd_cyc = cyc;
    end
    if (frame_done === 1'b1) begin
      done_cnt++;
      last_done_cyc  = cyc;
      last_done_busy = busy;
    end
  end

  // Serial decoder + scoreboard: every bit must hold for CPB cycles, and the
  // whole frame must match the oldest word written into the FIFO.
  initial begin : tx_monitor
    logic [FB-1:0] got;
    logic [FB-1:0] expf;
    logic [DW-1:0] eb;
    logic          glitch;
    logic          aborted;
    int            t0;
    int            k;
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && busy === 1'b1) begin
        t0 = cyc; got = '0; glitch = 1'b0; aborted = 1'b0; k = 0;
        while (k < FRAME && !aborted) begin
          if (k != 0) @(negedge clk);
          if (busy !== 1'b1) aborted = 1'b1;
          else if (k % CPB == 0) got[k / CPB] = tx;
          else if (tx !== got[k / CPB]) glitch = 1'b1;
          k++;
        end
        if (!aborted) begin
          start_q.push_back(t0);
          mon_frames++;
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL frame_unexpected: frame %b started at cycle %0d, required no frame", got, t0);
          end else begin
            eb = exp_q.pop_front();
`ifdef FIFO_UART_TX_PARITY_EN
            expf = {1'b1, ^eb, eb, 1'b0};
`else
            expf = {1'b1, eb, 1'b0};
`endif
            if (got !== expf || glitch) begin
              tests_failed++;
              $display("FAIL frame_bits: got %b glitch=%0b at cycle %0d, required %b (byte 0x%02h)",
                       got, glitch, t0, expf, eb);
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Advance n cycles; land just after the falling edge so outputs are stable
  // and bench bookkeeping of that edge has been done.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic fifo_write(input logic [DW-1:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    exp_q.push_back(v);
    tick(1);
    wr_en   = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget, output logic ok);
    int n = 0;
    while (mon_frames < target && n < budget) begin
      tick(1);
      n++;
    end
    ok = (mon_frames >= target);
  endtask

  task automatic wait_start(input int budget, output logic ok);
    int n = 0;
    while (!(tx === 1'b0 && busy === 1'b1) && n < budget) begin
      tick(1);
      n++;
    end
    ok = (tx === 1'b0 && busy === 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int base_rd;
    int bad;
    clr     = 1'b1;
    wr_en   = 1'b1;
    wr_data = DW'($urandom_range(0, 255));
    tick(2);
    wr_en = 1'b0;
    tests_run++;
    if (tx !== 1'b1) begin tests_failed++; $display("FAIL reset_tx: got %b required 1", tx); end
    tests_run++;
    if (fifo_rd_en !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_en: got %b required 0", fifo_rd_en); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b required 0", busy); end
    tests_run++;
    if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_done: got %b required 0", frame_done); end
    clr     = 1'b0;
    base_rd = rd_cnt;
    bad     = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (busy !== 1'b0 || fifo_rd_en !== 1'b0 || tx !== 1'b1) bad++;
    end
    tests_run++;
    if (bad != 0 || rd_cnt != base_rd) begin
      tests_failed++;
      $display("FAIL idle_empty: %0d non-idle cycles, %0d reads, required 0 and 0", bad, rd_cnt - base_rd);
    end
  endtask

  task automatic test_single_byte();
    int   base_rd, base_done, base_fr;
    logic ok;
    base_rd = rd_cnt; base_done = done_cnt; base_fr = mon_frames;
    fifo_write(8'hA5);
    wait_frames(base_fr + 1, 200, ok);
    tick(1);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL single_timeout: got %0d frames required %0d", mon_frames - base_fr, 1); end
    tests_run++;
    if (rd_cnt - base_rd != 1) begin tests_failed++; $display("FAIL single_rd_pulses: got %0d required 1", rd_cnt - base_rd); end
    tests_run++;
    if (done_cnt - base_done != 1) begin tests_failed++; $display("FAIL single_done_pulses: got %0d required 1", done_cnt - base_done); end
    if (ok) begin
      tests_run++;
      if (last_done_cyc - start_q[start_q.size()-1] != FRAME) begin
        tests_failed++;
        $display("FAIL single_done_latency: got %0d required %0d", last_done_cyc - start_q[start_q.size()-1], FRAME);
      end
    end
    tests_run++;
    if (last_done_busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_at_done: got %b required 0", last_done_busy); end
  endtask

  task automatic test_back_to_back();
    int   base_rd, base_fr, n;
    logic ok;
    base_rd = rd_cnt; base_fr = mon_frames;
    fifo_write(8'h00);
    fifo_write(8'hFF);
    fifo_write(8'h3C);
    wait_frames(base_fr + 3, 400, ok);
    tick(1);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL b2b_timeout: got %0d frames required 3", mon_frames - base_fr); end
    tests_run++;
    if (rd_cnt - base_rd != 3) begin tests_failed++; $display("FAIL b2b_rd_pulses: got %0d required 3", rd_cnt - base_rd); end
    if (ok) begin
      n = start_q.size();
      for (int i = n - 2; i < n; i++) begin
        tests_run++;
        if (start_q[i] - start_q[i-1] != SPACING) begin
          tests_failed++;
          $display("FAIL b2b_spacing: got %0d required %0d", start_q[i] - start_q[i-1], SPACING);
        end
      end
    end
    tests_run++;
    if (fifo_empty !== 1'b1) begin tests_failed++; $display("FAIL b2b_fifo_empty: got %b required 1", fifo_empty); end
  endtask

  task automatic test_mid_frame_reset();
    int   base_rd, base_done, base_fr, bad;
    logic ok;
    fifo_write(8'h5A);
    wait_start(50, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL midrst_no_start: got busy=%b tx=%b required a start bit", busy, tx); end
    tick(CPB + 3 * CPB + 1);          // inside data bit 3
    base_done = done_cnt;
    clr = 1'b1;
    tick(1);
    tests_run++;
    if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_outputs: got tx=%b busy=%b frame_done=%b required 1 0 0", tx, busy, frame_done);
    end
    clr = 1'b0;
    exp_q.delete();                   // the popped word is discarded
    base_rd = rd_cnt; base_fr = mon_frames; bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0 || rd_cnt != base_rd || mon_frames != base_fr || done_cnt != base_done) begin
      tests_failed++;
      $display("FAIL midrst_stays_idle: bad=%0d reads=%0d frames=%0d dones=%0d required all 0",
               bad, rd_cnt - base_rd, mon_frames - base_fr, done_cnt - base_done);
    end
  endtask

  task automatic test_late_arrival();
    int   base_rd, base_fr, n;
    logic ok;
    base_rd = rd_cnt; base_fr = mon_frames;
    fifo_write(8'hC3);
    wait_start(50, ok);
    tick(10);
    fifo_write(8'h81);
    tests_run++;
    if (rd_cnt - base_rd != 1) begin tests_failed++; $display("FAIL late_early_pop: got %0d reads required 1", rd_cnt - base_rd); end
    wait_frames(base_fr + 2, 300, ok);
    tick(1);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL late_timeout: got %0d frames required 2", mon_frames - base_fr); end
    if (ok) begin
      n = start_q.size();
      tests_run++;
      if (start_q[n-1] - start_q[n-2] != SPACING) begin
        tests_failed++;
        $display("FAIL late_spacing: got %0d required %0d", start_q[n-1] - start_q[n-2], SPACING);
      end
      tests_run++;
      if (last_rd_cyc != start_q[n-2] + FRAME + 1) begin
        tests_failed++;
        $display("FAIL late_pop_cycle: got %0d required %0d", last_rd_cyc, start_q[n-2] + FRAME + 1);
      end
    end
  endtask

  task automatic test_random();
    int   base_fr, base_done, cnt;
    logic ok;
    base_fr = mon_frames; base_done = done_cnt;
    cnt = 6;
    for (int i = 0; i < cnt; i++) begin
      fifo_write(DW'($urandom_range(0, 255)));
      tick($urandom_range(0, 60));
    end
    wait_frames(base_fr + cnt, 600, ok);
    tick(1);
    tests_run++;
    if (!ok || done_cnt - base_done != cnt) begin
      tests_failed++;
      $display("FAIL random_frames: got %0d frames %0d dones required %0d", mon_frames - base_fr, done_cnt - base_done, cnt);
    end
  endtask

`ifdef FIFO_UART_TX_PARITY_EN
  task automatic test_parity();
    int   base_fr, n;
    logic ok;
    base_fr = mon_frames;
    fifo_write(8'h07);                // parity bit 1
    fifo_write(8'h03);                // parity bit 0
    wait_frames(base_fr + 2, 300, ok);
    tick(1);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL parity_timeout: got %0d frames required 2", mon_frames - base_fr); end
    if (ok) begin
      n = start_q.size();
      tests_run++;
      if (start_q[n-1] - start_q[n-2] != 47) begin
        tests_failed++;
        $display("FAIL parity_spacing: got %0d required 47", start_q[n-1] - start_q[n-2]);
      end
      tests_run++;
      if (last_done_cyc - start_q[n-1] != 44) begin
        tests_failed++;
        $display("FAIL parity_frame_len: got %0d required 44", last_done_cyc - start_q[n-1]);
      end
    end
  endtask
`endif

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_mid_frame_reset();
    test_late_arrival();
    test_random();
`ifdef FIFO_UART_TX_PARITY_EN
    test_parity();
`endif
    tick(5);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d words never transmitted, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
